// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with frame-level debounce
// Emits the confirmed key as one-hot row/col plus a press strobe and held flag.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] kp_row_n,
  input  logic [3:0] kp_col_n,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       key_press,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DW_ONE   = DW'(1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_PRESSED, S_RELEASE} state_t;

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  logic [3:0]    r_col_s1, r_col_sync;
  logic [1:0]    r_ptr;
  logic [DW-1:0] r_dwell;
  logic          r_acc_any, r_acc_multi;
  logic [3:0]    r_acc_key;
  logic          r_res_valid;
  res_t          r_res_kind;
  logic [3:0]    r_res_key;

  logic          w_tick, w_hits_nz, w_hits_multi, w_frame_any, w_frame_multi;
  logic [3:0]    w_hits, w_frame_key;

  assign kp_row_n      = ~(4'b0001 << r_ptr);
  assign w_tick        = (r_dwell == DIV_LAST);
  assign w_hits        = ~r_col_sync;
  assign w_hits_nz     = |w_hits;
  assign w_hits_multi  = (w_hits & (w_hits - 4'd1)) != 4'd0;
  // A frame is MULTI once any row has several hits or hits appear in a second row.
  assign w_frame_any   = r_acc_any | w_hits_nz;
  assign w_frame_multi = r_acc_multi | w_hits_multi | (w_hits_nz & r_acc_any);
  assign w_frame_key   = w_hits_nz ? {r_ptr, enc(w_hits)} : r_acc_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_s1    <= 4'b1111;
      r_col_sync  <= 4'b1111;
      r_ptr       <= 2'd0;
      r_dwell     <= '0;
      r_acc_any   <= 1'b0;
      r_acc_multi <= 1'b0;
      r_acc_key   <= 4'd0;
      r_res_valid <= 1'b0;
      r_res_kind  <= RES_NONE;
      r_res_key   <= 4'd0;
    end else begin
      r_col_s1    <= kp_col_n;
      r_col_sync  <= r_col_s1;
      r_res_valid <= 1'b0;
      if (w_tick) begin
        r_dwell <= '0;
        r_ptr   <= r_ptr + 2'd1;
        if (r_ptr == 2'd3) begin
          r_res_valid <= 1'b1;
          r_res_kind  <= w_frame_multi ? RES_MULTI : (w_frame_any ? RES_SINGLE : RES_NONE);
          r_res_key   <= w_frame_key;
          r_acc_any   <= 1'b0;
          r_acc_multi <= 1'b0;
          r_acc_key   <= 4'd0;
        end else begin
          r_acc_any   <= w_frame_any;
          r_acc_multi <= w_frame_multi;
          r_acc_key   <= w_frame_key;
        end
      end else begin
        r_dwell <= r_dwell + DW_ONE;
      end
    end
  end

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [3:0]    r_row, r_col, w_row_nxt, w_col_nxt;
  logic          r_press, r_held, w_press_nxt, w_held_nxt;
  logic          w_is_cand, w_is_other, w_is_none;

  assign w_is_cand  = (r_res_kind == RES_SINGLE) && (r_res_key == r_cand);
  assign w_is_other = (r_res_kind == RES_SINGLE) && (r_res_key != r_cand);
  assign w_is_none  = (r_res_kind == RES_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'd0;
      r_row   <= 4'd0;
      r_col   <= 4'd0;
      r_press <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_press <= w_press_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_held_nxt  = r_held;
    w_press_nxt = 1'b0;
    if (r_res_valid) begin
      case (r_state)
        S_IDLE: begin
          if (r_res_kind == RES_SINGLE) begin
            w_cand_nxt = r_res_key;
            w_cnt_nxt  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt = S_PRESSED;
              w_row_nxt   = 4'b0001 << r_res_key[3:2];
              w_col_nxt   = 4'b0001 << r_res_key[1:0];
              w_press_nxt = 1'b1;
              w_held_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (w_is_cand) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt == DB_LAST) begin
              w_state_nxt = S_PRESSED;
              w_row_nxt   = 4'b0001 << r_cand[3:2];
              w_col_nxt   = 4'b0001 << r_cand[1:0];
              w_press_nxt = 1'b1;
              w_held_nxt  = 1'b1;
            end
          end else if (w_is_other) begin
            w_cand_nxt = r_res_key;
            w_cnt_nxt  = CNT_ONE;
          end else if (w_is_none) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (w_is_none || w_is_other) begin
            w_cnt_nxt = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt = S_IDLE;
              w_row_nxt   = 4'd0;
              w_col_nxt   = 4'd0;
              w_held_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // Key bounced back: resume holding without a second strobe.
          if (w_is_cand) begin
            w_state_nxt = S_PRESSED;
          end else if (w_is_none || w_is_other) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt == DB_LAST) begin
              w_state_nxt = S_IDLE;
              w_row_nxt   = 4'd0;
              w_col_nxt   = 4'd0;
              w_held_nxt  = 1'b0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign row       = r_row;
  assign col       = r_col;
  assign key_press = r_press;
  assign key_held  = r_held;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-side front end for the 4x4 keypad. It drives the keypad row strobes one at a time and samples the column returns. It debounces the result over whole scan frames. It then presents the confirmed key as one-hot `row`/`col` vectors, which feed the existing `keypad` decoder's `row`/`col` inputs, together with a one-cycle press strobe and a held flag.

## Interface
- `SCAN_DIV`, 50000: clock cycles each row is driven; minimum 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical frames required to confirm a press or a release; minimum 1.

- `clk` in 1: system clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `kp_row_n` out 4: row strobes to pins, active-low, exactly one bit low at all times.
- `kp_col_n` in 4: column returns from pins, pulled up, active-low, asynchronous.
- `row` out 4: confirmed key row, one-hot, bit i = row i; 0 when no key.
- `col` out 4: confirmed key column, one-hot, bit j = column j; 0 when no key.
- `key_press` out 1: one-cycle pulse when a press is confirmed.
- `key_held` out 1: high while a confirmed key is held, including during release counting.

## Operation
- `kp_col_n` passes through a 2-FF synchronizer, reset to 4'b1111.
- Scan pointer `r` runs 0..3 and wraps. `kp_row_n = ~(4'b0001 << r)`.
- Dwell counter runs 0..SCAN_DIV-1. On its terminal count:
  - sample `hits = ~col_sync`;
  - advance `r`;
  - clear the dwell counter.
- Frame accumulation covers rows 0..3 and yields one of three results:
  - NONE: no hits.
  - SINGLE(r,c): exactly one hit bit in exactly one row.
  - MULTI: any row with more than one hit, or hits in more than one row.
- The frame result is evaluated at the row-3 sample. Accumulators then clear.
- The FSM steps once per frame result. `cnt` is the frame counter and `cand` is the candidate key.
  - IDLE (row=col=0, held=0):
    - SINGLE(k): `cand=k`, `cnt=1`. Go to PRESSED if DEBOUNCE_SCANS==1, else to CONFIRM.
    - NONE or MULTI: stay.
  - CONFIRM:
    - SINGLE(cand): `cnt++`. On reaching DEBOUNCE_SCANS, go to PRESSED.
    - SINGLE(other): `cand=other`, `cnt=1`.
    - NONE: go to IDLE.
    - MULTI: no change.
  - PRESSED:
    - On entry from CONFIRM or IDLE: latch `row`/`col` from `cand`, set `key_press` for one cycle, set `key_held`.
    - SINGLE(cand) or MULTI: stay.
    - NONE or SINGLE(other): `cnt=1`. Go to IDLE if DEBOUNCE_SCANS==1, else to RELEASE.
  - RELEASE (outputs unchanged):
    - SINGLE(cand): return to PRESSED with no new `key_press`.
    - NONE or SINGLE(other): `cnt++`. On reaching DEBOUNCE_SCANS, go to IDLE and clear `row`, `col` and `key_held`.
    - MULTI: no change.
- `row`/`col` are only ever zero or a single one-hot pair. They never change while `key_held`=1.

## Timing
- Reset values: `kp_row_n`=4'b1110, `row`=0, `col`=0, `key_press`=0, `key_held`=0. Pointer, dwell counter, frame accumulators, `cnt` and `cand` are all 0. State is IDLE.
- Reset mid-operation discards any partial frame or confirm count and emits no pulse. Scanning restarts at row 0 on the first cycle after `reset` deasserts.
- One frame is 4·SCAN_DIV cycles.
- Each sample is taken SCAN_DIV-1 cycles after its row strobe changes, so the 2-cycle synchronizer has always settled.
- The FSM registers its update on the edge after the row-3 sample.
- `key_press`, `row`, `col` and `key_held` all change on that same edge.
- `key_press` is high for exactly 1 cycle per confirmed press.
- Press latency from a key stable before a frame starts: DEBOUNCE_SCANS frames plus 1 cycle.
- Release latency is the same measure.
- A key that closes mid-frame, after its row has already been sampled, costs one extra frame.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame is 16 cycles. The pin model drives `kp_col_n[c]` low iff `kp_row_n[r]` is low and key (r,c) is pressed.
- Reset for 2 cycles, then release:
  - outputs read `kp_row_n`=1110, `row`=0, `col`=0, `key_press`=0, `key_held`=0;
  - `kp_row_n` then steps 1101, 1011, 0111, 1110, every 4 cycles.
- Press (0,0) from cycle 0 after reset → exactly one `key_press` pulse, 1 cycle after the end of frame 2. `row`=0001, `col`=0001, `key_held`=1.
- Press (1,3) and hold → `row`=0010, `col`=1000, single pulse, no further pulses over 10 frames.
- Press (2,1) for one frame only → no `key_press`, `row`/`col` stay 0.
- Press (0,0) and (0,1) together (`kp_col_n`=1100 on row 0) → MULTI, no pulse.
- Release after a confirmed (3,2), i.e. `row`=1000, `col`=0100 → after 2 NONE frames `key_held`=0, `row`=0, `col`=0, no pulse.
- Pulse `reset` during CONFIRM (after frame 1 of a press) → no pulse, all outputs at reset values.
